// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared widths, control-bundle bit positions and the forwarding match helper
package rv32i_pkg;
    localparam int XLEN           = 32;
    localparam int CTRLW          = 12;
    localparam int CTRL_REGWR     = 0;
    localparam int CTRL_MEMRD     = 1;
    localparam int CTRL_MEMWR     = 2;
    localparam int CTRL_ALUSRC    = 3;
    localparam int CTRL_RESSRC_LO = 4;
    localparam int CTRL_RESSRC_HI = 5;
    localparam int CTRL_BRANCH    = 6;
    localparam int CTRL_JUMP      = 7;
    localparam int CTRL_ALUOP_LO  = 8;
    localparam int CTRL_ALUOP_HI  = 11;

    // x0 is never a forwarding target
    function automatic logic fwd_hit(input logic we, input logic [4:0] rd, input logic [4:0] src);
        return we && rd != 5'd0 && rd == src;
    endfunction
endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: EX-stage operand select, EX/MEM result over writeback result over captured value
module fwd_mux
    import rv32i_pkg::*;
#(
    parameter int XLEN = rv32i_pkg::XLEN
) (
    input  logic [4:0]      src,
    input  logic [XLEN-1:0] captured,
    input  logic [4:0]      exm_rd,
    input  logic            exm_we,
    input  logic [XLEN-1:0] exm_res,
    input  logic [4:0]      wb_rd,
    input  logic            wb_we,
    input  logic [XLEN-1:0] wb_res,
    output logic [XLEN-1:0] operand
);
    always_comb operand = fwd_hit(exm_we, exm_rd, src) ? exm_res :
                          fwd_hit(wb_we, wb_rd, src)   ? wb_res  : captured;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with writeback bypass on capture,
// EX-side operand forwarding and load-use stall/bubble generation.
module id_ex_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN  = rv32i_pkg::XLEN,
    parameter int CTRLW = rv32i_pkg::CTRLW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [CTRLW-1:0] id_ctrl,
    input  logic [XLEN-1:0]  rd1,
    input  logic [XLEN-1:0]  rd2,
    input  logic [4:0]       exm_rd,
    input  logic             exm_we,
    input  logic [XLEN-1:0]  exm_res,
    input  logic [4:0]       wb_rd,
    input  logic             wb_we,
    input  logic [XLEN-1:0]  wb_res,
    input  logic             flush,
    output logic             stall_id,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [CTRLW-1:0] ex_ctrl,
    output logic [XLEN-1:0]  ex_op1,
    output logic [XLEN-1:0]  ex_op2
);
    logic [XLEN-1:0] op1_q, op2_q;
    logic            kill;

    always_comb begin
        stall_id = !flush && ex_valid && ex_ctrl[CTRL_MEMRD] && ex_rd != 5'd0 && id_valid &&
                   (ex_rd == id_rs1 || ex_rd == id_rs2);
        kill     = flush || stall_id || !id_valid;
    end

    // Only valid/ctrl are squashed on a bubble; the remaining fields are don't-care then
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
            ex_pc    <= '0;
            ex_imm   <= '0;
            ex_rs1   <= '0;
            ex_rs2   <= '0;
            ex_rd    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
        end else begin
            ex_valid <= !kill;
            ex_ctrl  <= kill ? '0 : id_ctrl;
            ex_pc    <= id_pc;
            ex_imm   <= id_imm;
            ex_rs1   <= id_rs1;
            ex_rs2   <= id_rs2;
            ex_rd    <= id_rd;
            op1_q    <= fwd_hit(wb_we, wb_rd, id_rs1) ? wb_res : rd1;
            op2_q    <= fwd_hit(wb_we, wb_rd, id_rs2) ? wb_res : rd2;
        end
    end

    fwd_mux #(.XLEN(XLEN)) u_fwd1 (
        .src(ex_rs1), .captured(op1_q),
        .exm_rd(exm_rd), .exm_we(exm_we), .exm_res(exm_res),
        .wb_rd(wb_rd), .wb_we(wb_we), .wb_res(wb_res),
        .operand(ex_op1)
    );

    fwd_mux #(.XLEN(XLEN)) u_fwd2 (
        .src(ex_rs2), .captured(op2_q),
        .exm_rd(exm_rd), .exm_we(exm_we), .exm_res(exm_res),
        .wb_rd(wb_rd), .wb_we(wb_we), .wb_res(wb_res),
        .operand(ex_op2)
    );
endmodule
